// File: rtl/branch_commit_trainer.sv
// rtl/branch_commit_trainer.sv - commit-side branch training, mispredict flush and recovery hold-off
// Optional PRED_STATS_EN adds saturating branch/mispredict counters.
module branch_commit_trainer #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_ins,
  input  logic        commit_taken,
  input  logic [31:0] commit_target,
  input  logic [31:0] commit_pred_pc,
  output logic        enable_to_pred,
  output logic        if_jump,
  output logic [31:0] code,
  output logic [31:0] train_pc,
  output logic        flush_out,
  output logic [31:0] redirect_pc
`ifdef PRED_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        en_q, en_d;
  logic        if_jump_q, if_jump_d;
  logic [31:0] code_q, code_d;
  logic [31:0] train_pc_q, train_pc_d;
  logic        flush_q, flush_d;
  logic [31:0] redirect_q, redirect_d;

  logic [6:0]  opcode;
  logic        is_br;
  logic        is_ctrl;
  logic        acc;
  logic        mispred;
  logic [31:0] npc;

`ifdef PRED_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;
`endif

  always_comb begin
    opcode  = commit_ins[6:0];
    is_br   = (opcode == OP_BR);
    is_ctrl = is_br || (opcode == OP_JAL) || (opcode == OP_JALR);
    npc     = commit_taken ? commit_target : (commit_pc + 32'd4);
    acc     = commit_valid & ready_q & rdy;
    mispred = acc & is_ctrl & (commit_pred_pc != npc);

    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    en_d       = en_q;
    if_jump_d  = if_jump_q;
    code_d     = code_q;
    train_pc_d = train_pc_q;
    flush_d    = flush_q;
    redirect_d = redirect_q;

    // With rdy low every register holds, so a pending pulse survives until rdy returns.
    if (rdy) begin
      en_d    = acc & is_br;
      flush_d = 1'b0;
      if (acc && is_br) begin
        if_jump_d  = commit_taken;
        code_d     = commit_ins;
        train_pc_d = commit_pc;
      end

      unique case (state_q)
        IDLE: begin
          if (mispred) begin
            state_d    = FLUSH;
            cnt_d      = FLUSH_CNT;
            flush_d    = 1'b1;
            redirect_d = npc;
          end
        end
        FLUSH: begin
          state_d = RECOVER;
        end
        RECOVER: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase

      ready_d = (state_d == IDLE);
    end
  end

`ifdef PRED_STATS_EN
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (acc && is_ctrl && (stat_br_q != 32'hFFFF_FFFF)) begin
      stat_br_d = stat_br_q + 32'd1;
    end
    if (mispred && (stat_mp_q != 32'hFFFF_FFFF)) begin
      stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      ready_q    <= 1'b1;
      en_q       <= 1'b0;
      if_jump_q  <= 1'b0;
      code_q     <= 32'd0;
      train_pc_q <= 32'd0;
      flush_q    <= 1'b0;
      redirect_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      en_q       <= en_d;
      if_jump_q  <= if_jump_d;
      code_q     <= code_d;
      train_pc_q <= train_pc_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign commit_ready   = ready_q;
  assign enable_to_pred = en_q & rdy;
  assign flush_out      = flush_q & rdy;
  assign if_jump        = if_jump_q;
  assign code           = code_q;
  assign train_pc       = train_pc_q;
  assign redirect_pc    = redirect_q;

endmodule
